dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, request address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width, fixed to 32 in this release.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, named clock and reset.
REQ-004 SHALL have port clock  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-006 SHALL have, for each N in {0,1}, port reqN_valid  input  1  request present.
REQ-007 SHALL have, for each N in {0,1}, port reqN_ready  output  1  request accepted this cycle.
REQ-008 SHALL have, for each N in {0,1}, port reqN_addr  input  ADDR_W  byte address.
REQ-009 SHALL have, for each N in {0,1}, port reqN_write  input  1  1=store, 0=load.
REQ-010 SHALL have, for each N in {0,1}, port reqN_width  input  2  00 byte, 01 half, 1x word.
REQ-011 SHALL have, for each N in {0,1}, port reqN_sign  input  1  sign-extend loads.
REQ-012 SHALL have, for each N in {0,1}, port reqN_wdata  input  DATA_W  store data.
REQ-013 SHALL have, for each N in {0,1}, port rspN_valid  output  1  response pulse.
REQ-014 SHALL have, for each N in {0,1}, port rspN_rdata  output  DATA_W  load data.
REQ-015 SHALL have, for each N in {0,1}, port rspN_err  output  1  misaligned, not executed.
REQ-016 SHALL have ports mem_address (output, ADDR_W), mem_read (output, 1), mem_write (output, 1), mem_extendSign (output, 1) and mem_width (output, 2), which drive the data-memory request.
REQ-017 SHALL have ports mem_writeInput (output, DATA_W) and mem_readResult (input, DATA_W); memory reads are combinational and writes take effect at the clock edge.

Function
REQ-018 SHALL accept at most one request per cycle; reqN_ready SHALL be combinational and SHALL equal grant to N.
REQ-019 SHALL grant the only valid requester when exactly one requester is valid.
REQ-020 SHALL grant the requester named by the 1-bit register prio when both requesters are valid.
REQ-021 SHALL set prio to the other requester after any grant; prio SHALL be unchanged in cycles with no grant.
REQ-022 SHALL, in a grant cycle, drive mem_* from the granted requester, assert mem_read=!write or mem_write=write, and keep the remaining mem_* fields unchanged.
REQ-023 SHALL drive mem_read=0, mem_write=0 and all other mem_* outputs to 0 in cycles with no grant.
REQ-024 SHALL pulse rspN_valid for exactly one cycle, in the cycle after the grant to N (latency 1), for both loads and stores.
REQ-025 SHALL drive rspN_rdata from mem_readResult registered at the grant edge for loads, and SHALL drive it to 0 for stores and errors.
REQ-026 SHALL hold rspN_rdata until the next rspN_valid.
REQ-027 SHALL let back-to-back grants to the same requester in consecutive cycles produce consecutive rspN_valid pulses.
REQ-028 SHALL, as a requester rule, keep reqN_* stable while reqN_valid=1 and reqN_ready=0; the bench SHALL flag violations.
REQ-029 SHALL grant a sustained requester within 2 cycles; a requester SHALL never wait more than 1 grant of the other.
REQ-030 SHALL, when the width field is 1x, treat address[1:0] as ignored by memory; the word is aligned down.

Reset
REQ-031 SHALL, on reset assertion (asynchronous), immediately set prio=0, rspN_valid=0, rspN_rdata=0, rspN_err=0, reqN_ready=0 and all mem_* outputs to 0.
REQ-032 SHALL drop any response pending at reset; a store granted in the same cycle that reset rises SHALL NOT reach memory (mem_write forced 0).
REQ-033 SHALL resume arbitration on the first rising clock edge after reset deasserts.

Configuration
REQ-034 SHALL, with DMEM_ARB_ALIGN_CHK_EN defined, treat a request with a half width at address[0]=1, or a word width at address[1:0]!=0, as misaligned.
REQ-035 SHALL, for a misaligned request with DMEM_ARB_ALIGN_CHK_EN defined, grant it normally, keep mem_read=0 and mem_write=0, and pulse rspN_valid with rspN_err=1 and rspN_rdata=0 in the next cycle.
REQ-036 SHALL, without DMEM_ARB_ALIGN_CHK_EN, tie rspN_err to 0 and pass all requests to memory unchecked.

Verification
REQ-037 SHALL cover a single load: req0 loads word @0x10 (mem holds 0xDEADBEEF) -> ready0=1 in the same cycle; next cycle rsp0_valid=1, rsp0_rdata=0xDEADBEEF.
REQ-038 SHALL cover contention: both requesters valid for 4 cycles after reset -> grants 0,1,0,1 and rsp pulses alternate.
REQ-039 SHALL cover a store then a load: req1 stores byte 0x80 @0x21, then req0 loads a signed byte @0x21 -> rsp0_rdata=0xFFFFFF80; an unsigned load gives 0x00000080.
REQ-040 SHALL cover a misaligned word: word @0x22 with DMEM_ARB_ALIGN_CHK_EN -> no mem_write, rsp_err=1; without the macro -> the store reaches word 0x20, rsp_err=0.
REQ-041 SHALL cover reset mid-operation: reset rises asynchronously in the same cycle as a req0 store grant -> rsp0_valid=0, the memory word is unchanged and prio=0 after reset.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-port arbiter in front of a single data memory. Each requester issues
//   load/store requests; at most one is granted per cycle and forwarded to the
//   memory port. The response (load data or store acknowledge) comes back
//   exactly one cycle after the grant. Contention is resolved by a 1-bit
//   round-robin priority register.
//
//   Build option: define DMEM_ARB_ALIGN_CHK_EN to flag misaligned half/word
//   requests. Such requests are still granted, but they are not sent to memory
//   and are answered with rspN_err=1. When the macro is not defined, every
//   request goes to memory unchecked and rspN_err stays 0.
//
// Ports
//   clock, reset               rising-edge clock, async active-high reset
//   reqN_valid/ready           request handshake (ready = combinational grant)
//   reqN_addr/write/width/sign request attributes (width 00 byte, 01 half, 1x word)
//   reqN_wdata                 store data
//   rspN_valid/rdata/err       one-cycle response pulse, held load data, error
//   mem_*                      data-memory request; reads are combinational
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic              req0_write,
    input  logic [1:0]        req0_width,
    input  logic              req0_sign,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic              req1_write,
    input  logic [1:0]        req1_width,
    input  logic              req1_sign,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,

    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_extendSign,
    output logic [1:0]        mem_width,
    output logic [DATA_W-1:0] mem_writeInput,
    input  logic [DATA_W-1:0] mem_readResult
);

    logic prio;
    logic grant0;
    logic grant1;
    logic mis0;
    logic mis1;

`ifdef DMEM_ARB_ALIGN_CHK_EN
    assign mis0 = ((req0_width == 2'b01) && req0_addr[0]) ||
                  (req0_width[1] && (req0_addr[1:0] != 2'b00));
    assign mis1 = ((req1_width == 2'b01) && req1_addr[0]) ||
                  (req1_width[1] && (req1_addr[1:0] != 2'b00));
`else
    assign mis0 = 1'b0;
    assign mis1 = 1'b0;
`endif

    // Grants are masked by reset so that a store presented while reset rises
    // never reaches memory, even before the next clock edge.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (req0_valid && req1_valid) begin
                grant0 = ~prio;
                grant1 = prio;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        mem_address    = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_extendSign = 1'b0;
        mem_width      = 2'b00;
        mem_writeInput = '0;
        if (grant0) begin
            mem_address    = req0_addr;
            mem_read       = ~req0_write & ~mis0;
            mem_write      = req0_write & ~mis0;
            mem_extendSign = req0_sign;
            mem_width      = req0_width;
            mem_writeInput = req0_wdata;
        end else if (grant1) begin
            mem_address    = req1_addr;
            mem_read       = ~req1_write & ~mis1;
            mem_write      = req1_write & ~mis1;
            mem_extendSign = req1_sign;
            mem_width      = req1_width;
            mem_writeInput = req1_wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prio       <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_rdata <= '0;
            rsp1_err   <= 1'b0;
        end else begin
            // After a grant to 0 the next tie goes to 1, and vice versa.
            if (grant0 || grant1) begin
                prio <= grant0;
            end
            rsp0_valid <= grant0;
            rsp1_valid <= grant1;
            if (grant0) begin
                rsp0_rdata <= (!req0_write && !mis0) ? mem_readResult : '0;
                rsp0_err   <= mis0;
            end
            if (grant1) begin
                rsp1_rdata <= (!req1_write && !mis1) ? mem_readResult : '0;
                rsp1_err   <= mis1;
            end
        end
    end

endmodule
